led_sequencer: RTL and testbench



---
 rtl/led_sequencer.sv | 145 ++++++++++++++
 tb/tb_led_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern generator: programmable prescaler driving rotate, bounce, count and fill patterns.
// Optional LED_SEQ_PWM_EN adds a 4-bit brightness input that PWM-gates the LED outputs.
module led_sequencer #(
   parameter int N_LEDS     = 4,
   parameter int PRESCALE_W = 22
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic [PRESCALE_W-1:0] period,
`ifdef LED_SEQ_PWM_EN
   input  logic [3:0]            brightness,
`endif
   output logic [N_LEDS-1:0]     leds,
   output logic                  step,
   output logic                  wrap
);

   typedef enum logic [1:0] {
      MODE_ROTATE = 2'b00,
      MODE_BOUNCE = 2'b01,
      MODE_COUNT  = 2'b10,
      MODE_FILL   = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam logic [N_LEDS-1:0] LED_ONE  = {{(N_LEDS-1){1'b0}}, 1'b1};
   localparam logic [N_LEDS-1:0] LED_ALL  = {N_LEDS{1'b1}};
   localparam logic [N_LEDS-1:0] LED_ZERO = {N_LEDS{1'b0}};

   logic [PRESCALE_W-1:0] presc_q;
   logic                  tick;
   mode_t                 mode_q, mode_nxt, mode_in;
   dir_t                  dir_q, dir_nxt;
   logic [N_LEDS-1:0]     pattern_q, pattern_nxt;
   logic                  wrap_nxt;
   logic                  step_q, wrap_q;

   function automatic logic [N_LEDS-1:0] start_pattern(input mode_t m);
      return (m == MODE_ROTATE || m == MODE_BOUNCE) ? LED_ONE : LED_ZERO;
   endfunction

   assign mode_in = mode_t'(mode);
   assign tick    = enable && (presc_q == period);

   // Prescaler: no clamp when period drops below the count; it simply wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
      end else if (enable) begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
      end
   end

   always_comb begin
      mode_nxt    = mode_q;
      dir_nxt     = dir_q;
      pattern_nxt = pattern_q;
      wrap_nxt    = 1'b0;
      if (tick) begin
         if (mode_in != mode_q) begin
            mode_nxt    = mode_in;
            dir_nxt     = DIR_UP;
            pattern_nxt = start_pattern(mode_in);
         end else begin
            case (mode_q)
               MODE_ROTATE: begin
                  pattern_nxt = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
                  wrap_nxt    = pattern_q[N_LEDS-1];
               end
               MODE_BOUNCE: begin
                  // Direction flips on landing at an end bit, so no end state repeats.
                  if (dir_q == DIR_UP) begin
                     pattern_nxt = pattern_q << 1;
                     if (pattern_nxt[N_LEDS-1]) dir_nxt = DIR_DOWN;
                  end else begin
                     pattern_nxt = pattern_q >> 1;
                     if (pattern_nxt[0]) begin
                        dir_nxt  = DIR_UP;
                        wrap_nxt = 1'b1;
                     end
                  end
               end
               MODE_COUNT: begin
                  pattern_nxt = pattern_q + LED_ONE;
                  wrap_nxt    = (pattern_q == LED_ALL);
               end
               default: begin
                  if (pattern_q == LED_ALL) begin
                     pattern_nxt = LED_ZERO;
                     wrap_nxt    = 1'b1;
                  end else begin
                     pattern_nxt = {pattern_q[N_LEDS-2:0], 1'b1};
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q    <= MODE_ROTATE;
         dir_q     <= DIR_UP;
         pattern_q <= LED_ONE;
         step_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         mode_q    <= mode_nxt;
         dir_q     <= dir_nxt;
         pattern_q <= pattern_nxt;
         step_q    <= tick;
         wrap_q    <= wrap_nxt;
      end
   end

   assign step = step_q;
   assign wrap = wrap_q;

`ifdef LED_SEQ_PWM_EN
   logic [3:0]        pwm_cnt_q;
   logic [N_LEDS-1:0] leds_q;

   // PWM counter free-runs regardless of enable; leds track the same-edge pattern update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_q <= 4'd0;
         leds_q    <= LED_ONE;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 4'd1;
         leds_q    <= pattern_nxt & {N_LEDS{pwm_cnt_q <= brightness}};
      end
   end

   assign leds = leds_q;
`else
   assign leds = pattern_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: expected LED updates are queued as stimulus is set up
// and compared against each step pulse, including its spacing in clock cycles.
module tb_led_sequencer;

   localparam int N  = 4;
   localparam int PW = 22;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [1:0]    mode;
   logic [PW-1:0] period;
   logic [N-1:0]  leds;
   logic          step;
   logic          wrap;
`ifdef LED_SEQ_PWM_EN
   logic [3:0]    brightness;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [N-1:0] leds;
      logic         wrap;
   } exp_t;

   exp_t sb[$];

   led_sequencer #(.N_LEDS(N), .PRESCALE_W(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .mode       (mode),
      .period     (period),
`ifdef LED_SEQ_PWM_EN
      .brightness (brightness),
`endif
      .leds       (leds),
      .step       (step),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [N-1:0] l, input logic w);
      exp_t e;
      e.leds = l;
      e.wrap = w;
      sb.push_back(e);
   endtask

   // Pop each queued update, wait for its step pulse (bounded), check spacing and values.
   task automatic drain(input string tag, input int gap);
      exp_t e;
      int   n;
      bit   seen;
      while (sb.size() > 0) begin
         e    = sb.pop_front();
         n    = 0;
         seen = 1'b0;
         while (!seen && n < gap + 2) begin
            @(negedge clk);
            n++;
            if (step === 1'b1) seen = 1'b1;
         end
         chk({tag, "_step_seen"}, 32'(seen), 32'd1);
         chk({tag, "_step_gap"}, 32'(n), 32'(gap));
         chk({tag, "_leds"}, 32'(leds), 32'(e.leds));
         chk({tag, "_wrap"}, 32'(wrap), 32'(e.wrap));
      end
   endtask

   initial begin
      int stepcnt;
      int hicnt;
      rst    = 1'b1;
      enable = 1'b0;
      mode   = 2'b00;
      period = PW'(3);
`ifdef LED_SEQ_PWM_EN
      brightness = 4'd15;
`endif
      repeat (3) @(negedge clk);
      chk("reset_leds", 32'(leds), 32'h1);
      chk("reset_step", 32'(step), 32'h0);
      chk("reset_wrap", 32'(wrap), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_leds", 32'(leds), 32'h1);

      // Rotate at period 3: one update every 4 cycles, wrap on MSB -> LSB.
      enable = 1'b1;
      push(4'b0010, 1'b0);
      push(4'b0100, 1'b0);
      push(4'b1000, 1'b0);
      push(4'b0001, 1'b1);
      drain("rotate", 4);

      // Bounce at period 0: reload first, then ping-pong with no repeated end.
      mode   = 2'b01;
      period = PW'(0);
      push(4'b0001, 1'b0);
      push(4'b0010, 1'b0);
      push(4'b0100, 1'b0);
      push(4'b1000, 1'b0);
      push(4'b0100, 1'b0);
      push(4'b0010, 1'b0);
      push(4'b0001, 1'b1);
      drain("bounce", 1);

      // Binary count: reload to 0, count up to 15, wrap back to 0.
      mode = 2'b10;
      push(4'b0000, 1'b0);
      for (int i = 1; i < 16; i++) push(4'(i), 1'b0);
      push(4'b0000, 1'b1);
      drain("count", 1);

      // Fill: reload to 0, fill from bit 0, clear after all-ones.
      mode = 2'b11;
      push(4'b0000, 1'b0);
      push(4'b0001, 1'b0);
      push(4'b0011, 1'b0);
      push(4'b0111, 1'b0);
      push(4'b1111, 1'b0);
      push(4'b0000, 1'b1);
      drain("fill", 1);

      // Back to rotate at period 3, then change mode mid-period at 0100.
      mode   = 2'b00;
      period = PW'(3);
      push(4'b0001, 1'b0);
      push(4'b0010, 1'b0);
      push(4'b0100, 1'b0);
      drain("rot2", 4);
      @(negedge clk);
      mode = 2'b10;
      chk("midmode_hold0", 32'(leds), 32'h4);
      @(negedge clk);
      chk("midmode_hold1", 32'(leds), 32'h4);
      chk("midmode_nostep", 32'(step), 32'h0);
      push(4'b0000, 1'b0);
      drain("midmode_reload", 2);
      push(4'b0001, 1'b0);
      push(4'b0010, 1'b0);
      drain("count2", 4);

      // Freeze mid-count at 0010: no steps, and the prescaler resumes where it stopped.
      repeat (2) @(negedge clk);
      enable  = 1'b0;
      stepcnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (step !== 1'b0) stepcnt++;
      end
      chk("freeze_nostep", 32'(stepcnt), 32'd0);
      chk("freeze_leds", 32'(leds), 32'h2);
      enable = 1'b1;
      push(4'b0011, 1'b0);
      drain("resume", 2);

      // Asynchronous reset between clock edges.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_leds", 32'(leds), 32'h1);
      chk("async_rst_step", 32'(step), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      push(4'b0000, 1'b0);
      drain("post_rst_reload", 4);

`ifdef LED_SEQ_PWM_EN
      // Pattern frozen at 0001 in rotate; measure leds[0] duty over 16 cycles.
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      enable     = 1'b0;
      mode       = 2'b00;
      brightness = 4'd3;
      repeat (2) @(negedge clk);
      hicnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (leds[0] === 1'b1) hicnt++;
      end
      chk("pwm_b3_duty", 32'(hicnt), 32'd4);
      brightness = 4'd15;
      repeat (2) @(negedge clk);
      hicnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (leds[0] === 1'b1) hicnt++;
      end
      chk("pwm_b15_duty", 32'(hicnt), 32'd16);
`else
      hicnt = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
